// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked EX-stage ALU; ALU_SEQ_MULDIV_EN adds iterative MUL/DIV/REM
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       alu_ctl,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             lt_zero
);
    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b10000;
    localparam logic [4:0] OP_SRL = 5'b11000;
    localparam logic [4:0] OP_SRA = 5'b11001;
    localparam logic [4:0] OP_MUL = 5'b11010;
    localparam logic [4:0] OP_DIV = 5'b11011;
    localparam logic [4:0] OP_REM = 5'b11100;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] quick_res;
    logic [WIDTH-1:0] eng_res;
    logic [SHW-1:0]   shamt;
    logic             slt;
    logic             is_long;
    logic             eng_done;
    logic             accept;

    assign shamt = in1[SHW-1:0];
    assign slt   = sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        quick_res = '0;
        case (alu_ctl)
            OP_AND:  quick_res = in1 & in2;
            OP_OR:   quick_res = in1 | in2;
            OP_ADD:  quick_res = in1 + in2;
            OP_SUB:  quick_res = in1 - in2;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR:  quick_res = ~(in1 | in2);
            OP_XOR:  quick_res = in1 ^ in2;
            OP_SLL:  quick_res = in2 << shamt;
            OP_SRL:  quick_res = in2 >> shamt;
            OP_SRA:  quick_res = $signed(in2) >>> shamt;
            default: quick_res = '0;
        endcase
    end

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

    kind_t            kind_q, kind_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, dvd_q, dvd_d;
    logic [WIDTH-1:0] mag1, mag2, raw;
    logic [WIDTH:0]   trial, diff;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fin_q, fin_d, neg_q, neg_d, dvz_q, dvz_d;
    logic             s1, s2;

    assign is_long = (alu_ctl == OP_MUL) || (alu_ctl == OP_DIV) || (alu_ctl == OP_REM);
    assign s1      = sign & in1[WIDTH-1];
    assign s2      = sign & in2[WIDTH-1];
    assign mag1    = s1 ? -in1 : in1;
    assign mag2    = s2 ? -in2 : in2;
    // a_q is the multiplicand for MUL and the dividend/quotient shift register for DIV/REM
    assign trial   = {acc_q, a_q[WIDTH-1]};
    assign diff    = trial - {1'b0, b_q};
    assign eng_done = fin_q;

    always_comb begin
        raw     = (kind_q == K_DIV) ? a_q : acc_q;
        eng_res = neg_q ? -raw : raw;
        if (dvz_q && (kind_q == K_DIV)) eng_res = '1;
        if (dvz_q && (kind_q == K_REM)) eng_res = dvd_q;
    end

    always_comb begin
        kind_d = kind_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        dvd_d  = dvd_q;
        cnt_d  = cnt_q;
        fin_d  = fin_q;
        neg_d  = neg_q;
        dvz_d  = dvz_q;
        if (flush) begin
            cnt_d = '0;
            fin_d = 1'b0;
        end else if (accept && is_long) begin
            kind_d = (alu_ctl == OP_MUL) ? K_MUL : ((alu_ctl == OP_DIV) ? K_DIV : K_REM);
            a_d    = mag1;
            b_d    = mag2;
            acc_d  = '0;
            dvd_d  = in1;
            cnt_d  = '0;
            fin_d  = 1'b0;
            neg_d  = (alu_ctl == OP_REM) ? s1 : (s1 ^ s2);
            dvz_d  = (in2 == '0);
        end else if ((state_q == S_BUSY) && !fin_q) begin
            cnt_d = cnt_q + 1'b1;
            fin_d = &cnt_q;
            if (kind_q == K_MUL) begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end else if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = trial[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
        end else if (state_q == S_BUSY) begin
            fin_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q <= K_MUL;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            dvd_q  <= '0;
            cnt_q  <= '0;
            fin_q  <= 1'b0;
            neg_q  <= 1'b0;
            dvz_q  <= 1'b0;
        end else begin
            kind_q <= kind_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_d;
            fin_q  <= fin_d;
            neg_q  <= neg_d;
            dvz_q  <= dvz_d;
        end
    end
`else
    assign is_long  = 1'b0;
    assign eng_done = 1'b0;
    assign eng_res  = '0;
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_BUSY: begin
                    if (eng_done) begin
                        state_d = S_DONE;
                        res_d   = eng_res;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: ;
            endcase
            if (accept) begin
                if (is_long) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_DONE;
                    res_d   = quick_res;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign out       = res_q;
    assign zero      = (res_q == '0);
    assign lt_zero   = res_q[WIDTH-1];
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq against a behavioural reference model
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [4:0]   alu_ctl = '0;
    logic         sign = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         zero;
    logic         lt_zero;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        int           lat;
        bit           seen;
    } exp_t;
    exp_t q[$];

    int ops[13] = '{0, 1, 2, 6, 7, 12, 13, 16, 24, 25, 26, 27, 28};

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in1(in1), .in2(in2), .alu_ctl(alu_ctl), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero),
        .lt_zero(lt_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        fails++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic bit long_op(input logic [4:0] op);
`ifdef ALU_SEQ_MULDIV_EN
        return (op == 5'd26) || (op == 5'd27) || (op == 5'd28);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic s);
        longint ua = {32'h0, a};
        longint ub = {32'h0, b};
        longint sa = {{32{a[31]}}, a};
        longint sb = {{32{b[31]}}, b};
        longint x = s ? sa : ua;
        longint y = s ? sb : ub;
        longint r = 0;
        case (op)
            5'd0:  r = ua & ub;
            5'd1:  r = ua | ub;
            5'd2:  r = ua + ub;
            5'd6:  r = ua - ub;
            5'd7:  r = (x < y) ? 1 : 0;
            5'd12: r = ~(ua | ub);
            5'd13: r = ua ^ ub;
            5'd16: r = ub << a[4:0];
            5'd24: r = ub >> a[4:0];
            5'd25: r = sb >>> a[4:0];
`ifdef ALU_SEQ_MULDIV_EN
            5'd26: r = x * y;
            5'd27: r = (b == 0) ? -1 : x / y;
            5'd28: r = (b == 0) ? ua : x % y;
`endif
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    always @(negedge clk) begin
        if (reset_n && !flush) begin
            if (out_valid) begin
                chk("result_pending", {31'b0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    if (!q[0].seen) begin
                        chk("latency", 32'(cyc), 32'(q[0].acc + q[0].lat));
                        q[0].seen = 1'b1;
                    end
                    chk("out", out, q[0].res);
                    chk("zero", {31'b0, zero}, {31'b0, q[0].res == '0});
                    chk("lt_zero", {31'b0, lt_zero}, {31'b0, q[0].res[W-1]});
                    if (out_ready) void'(q.pop_front());
                end
            end else if (q.size() != 0 && q[0].acc <= cyc) begin
                chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit rnd_rdy);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        alu_ctl  = op;
        in1      = a;
        in2      = b;
        sign     = s;
        forever begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                e.res  = model(op, a, b, s);
                e.acc  = cyc + 1;
                e.lat  = long_op(op) ? W + 1 : 0;
                e.seen = 1'b0;
                q.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                bound_expired("accept_timeout");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
        alu_ctl  = 5'($urandom);
        sign     = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        if (q.size() != 0) bound_expired("drain_timeout");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            tick(1);
            n++;
        end
        if (!out_valid) bound_expired("wait_valid_timeout");
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tick(3);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_lt_zero", {31'b0, lt_zero}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        tick(1);

        out_ready = 1'b1;
        send(5'd2,  32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(5'd6,  32'd5, 32'd5, 1'b0, 1'b0);
        send(5'd7,  32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        send(5'd7,  32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(5'd25, 32'd4, 32'h8000_0000, 1'b0, 1'b0);
        send(5'd26, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
        send(5'd27, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        send(5'd28, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        send(5'd27, 32'd9, 32'd0, 1'b0, 1'b0);
        send(5'd28, 32'd9, 32'd0, 1'b0, 1'b0);
        send(5'd27, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(5'd28, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(5'd31, 32'd3, 32'd4, 1'b0, 1'b0);
        drain();

        // result held under backpressure, then released together with a new request
        out_ready = 1'b0;
        send(5'd27, 32'd100, 32'd7, 1'b0, 1'b0);
        wait_valid();
        tick(10);
        out_ready = 1'b1;
        send(5'd2, 32'd3, 32'd4, 1'b0, 1'b0);
        drain();

        out_ready = 1'b0;
        send(5'd26, 32'd1234, 32'd5678, 1'b0, 1'b0);
        tick(4);
        flush = 1'b1;
        in_valid = 1'b1;
        alu_ctl = 5'd2;
        q.delete();
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_busy_in_ready", {31'b0, in_ready}, 32'd1);
        flush = 1'b1;
        in_valid = 1'b1;
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_no_accept", {31'b0, out_valid}, 32'd0);
        tick(3);
        chk("flush_idle_stays", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b1;
        send(5'd27, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
        tick(10);
        #1;
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("rst_mid_out", out, 32'd0);
        chk("rst_mid_zero", {31'b0, zero}, 32'd1);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        send(5'd2, 32'd1, 32'd2, 1'b0, 1'b0);
        send(5'd28, 32'hFFFF_FF00, 32'd7, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(ops[$urandom_range(0, 12)]);
            send(op, pick(), pick(), 1'($urandom), 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the pipeline's combinational ALU, used in the EX stage. It performs the existing single-cycle operation set at configurable WIDTH and adds iterative multiply, divide and remainder. Each request is accepted through a valid/ready handshake and the result is held until the consumer accepts it. The hazard unit uses `in_ready` as the EX stall source.

## Interface
- `WIDTH`, 32: operand and result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): width of the shift-amount field.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of the current operation and any held result.
- `in_valid` input 1: request present.
- `in_ready` output 1: request accepted on the edge where `in_valid && in_ready`.
- `in1`, `in2` input WIDTH: operands; shift amount is `in1[SHW-1:0]`, shifted value is `in2`.
- `alu_ctl` input 5: operation code.
- `sign` input 1: signed SLT/MUL/DIV/REM when 1, unsigned when 0.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes the result on the edge where `out_valid && out_ready`.
- `out` output WIDTH: result.
- `zero` output 1: `out == 0`.
- `lt_zero` output 1: `out[WIDTH-1]`.

## Operation
- Opcodes:
  - 00000 AND; 00001 OR; 00010 ADD; 00110 SUB, both modulo 2^WIDTH.
  - 00111 SLT: 1 or 0, zero-extended; signed compare if `sign`.
  - 01100 NOR; 01101 XOR.
  - 10000 SLL; 11000 SRL; 11001 SRA.
  - 11010 MUL: low WIDTH bits of the product.
  - 11011 DIV: quotient truncated toward zero.
  - 11100 REM: sign of the remainder follows the dividend.
  - Any other code gives result 0 at single-cycle latency.
- States:
  - IDLE: `in_ready=1`. On accept, a single-cycle op goes to DONE; MUL/DIV/REM go to BUSY.
  - BUSY: `in_ready=0`. Processes one operand bit per cycle; a cycle counter runs 0..WIDTH-1.
    - Signed operands are converted to magnitudes at accept.
    - Sign fix-up is applied on the transition into DONE.
  - DONE: `out_valid=1`. `out`, `zero` and `lt_zero` are stable until the handshake completes.
    - `in_ready = out_ready`, so back-to-back operation is allowed.
    - Handshake with no new request goes to IDLE; handshake plus accept starts the new op.
- MUL is radix-2 shift-add; DIV/REM is restoring division.
- Divide by zero: DIV = all ones; REM = dividend. No exception.
- Signed overflow (most-negative ÷ −1): DIV = dividend; REM = 0.
- `flush` wins over every other input: the next state is IDLE, `out_valid` deasserts, and any request presented in that cycle is not accepted.

## Timing
- Reset values: state IDLE, `out_valid=0`, `out=0`, `zero=1`, `lt_zero=0`, counter 0.
- `in_ready` resets to 1 and is combinational from state and `out_ready`.
- Single-cycle ops accepted at edge k: `out_valid=1` after edge k (1-cycle latency).
- MUL/DIV/REM accepted at edge k: BUSY for edges k+1..k+WIDTH; `out_valid=1` after edge k+WIDTH+1.
- Operands and opcode are captured at accept; later changes on the inputs are ignored.
- Reset assertion mid-BUSY or mid-DONE: immediate return to reset values with no result emitted; the first request after deassertion behaves normally.
- `out_ready` held low: DONE persists indefinitely with outputs unchanged.

## Configuration
- `ALU_SEQ_MULDIV_EN`:
  - Defined: MUL/DIV/REM engine, counter and BUSY state are present, as above.
  - Undefined: no BUSY state and no engine; opcodes 11010/11011/11100 complete at single-cycle latency with result 0.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1, `out_ready=1` → after 1 cycle `out=0x80000000`, `lt_zero=1`, `zero=0`; SUB 5−5 → `out=0`, `zero=1`.
- SLT `in1=0xFFFFFFFF`, `in2=1`: `sign=1` → 1; `sign=0` → 0. SRA `in1=4`, `in2=0x80000000` → `0xF8000000`.
- MUL signed −3×7 → `out=0xFFFFFFEB`, exactly 33 cycles after accept; `in_ready=0` for those 32 BUSY cycles.
- DIV signed −7/2 → `0xFFFFFFFD`; REM → `0xFFFFFFFF`; DIV 9/0 → `0xFFFFFFFF`; REM 9/0 → 9; DIV 0x80000000/−1 signed → `0x80000000`.
- Backpressure and back-to-back:
  - `out_ready=0` for 10 cycles after a DIV completes → `out` stable.
  - Then `out_ready=1` with a new ADD presented → ADD accepted in the same cycle and its result appears 1 cycle later.
- `flush` at BUSY cycle 5 of a MUL → IDLE next cycle, no `out_valid`; `reset_n` low mid-DIV → `out=0`, `zero=1` immediately.
